// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two per-source result FIFOs drained round-robin onto a registered broadcast.
// Optional build macro CDB_BYPASS_EN lets a winning result skip an empty FIFO for one-edge latency.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_BITS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [31:0]         alu_val,
    input  logic [ROB_BITS-1:0] alu_rob_pos,
    input  logic                alu_j,
    input  logic [31:0]         alu_pc,
    output logic                alu_afull,
    input  logic                lsb_valid,
    output logic                lsb_ready,
    input  logic [31:0]         lsb_val,
    input  logic [ROB_BITS-1:0] lsb_rob_pos,
    output logic                lsb_afull,
    output logic                cdb_valid,
    output logic                cdb_src,
    output logic [31:0]         cdb_val,
    output logic [ROB_BITS-1:0] cdb_rob_pos,
    output logic                cdb_j,
    output logic [31:0]         cdb_pc
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [31:0]         val;
        logic [ROB_BITS-1:0] rob_pos;
        logic                j;
        logic [31:0]         pc;
    } alu_entry_t;

    typedef struct packed {
        logic [31:0]         val;
        logic [ROB_BITS-1:0] rob_pos;
    } lsb_entry_t;

    alu_entry_t       alu_mem [FIFO_DEPTH];
    lsb_entry_t       lsb_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] alu_rd, alu_wr, lsb_rd, lsb_wr;
    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    logic             rr_lsb_last;

    alu_entry_t alu_in, alu_nxt;
    lsb_entry_t lsb_in, lsb_nxt;
    logic alu_fire, lsb_fire, alu_head, lsb_head, alu_cand, lsb_cand;
    logic grant_alu, grant_lsb, alu_enq, lsb_enq, alu_deq, lsb_deq;

    assign alu_in = {alu_val, alu_rob_pos, alu_j, alu_pc};
    assign lsb_in = {lsb_val, lsb_rob_pos};

    // Ready and almost-full look only at registered counts and the global rdy.
    assign alu_ready = rdy && (alu_cnt < DEPTH_C);
    assign lsb_ready = rdy && (lsb_cnt < DEPTH_C);
    assign alu_afull = (alu_cnt >= AFULL_C);
    assign lsb_afull = (lsb_cnt >= AFULL_C);

    assign alu_fire = alu_valid && alu_ready;
    assign lsb_fire = lsb_valid && lsb_ready;
    assign alu_head = (alu_cnt != '0);
    assign lsb_head = (lsb_cnt != '0);

`ifdef CDB_BYPASS_EN
    assign alu_cand = alu_head || alu_fire;
    assign lsb_cand = lsb_head || lsb_fire;
`else
    assign alu_cand = alu_head;
    assign lsb_cand = lsb_head;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_lsb = 1'b0;
        grant_alu = 1'b0;
        if (lsb_cand && (!alu_cand || !rr_lsb_last)) begin
            grant_lsb = 1'b1;
        end else if (alu_cand) begin
            grant_alu = 1'b1;
        end
    end

    // A grant with an empty FIFO can only be the bypassed incoming result.
    assign alu_deq = grant_alu && alu_head;
    assign lsb_deq = grant_lsb && lsb_head;
    assign alu_enq = alu_fire && !(grant_alu && !alu_head);
    assign lsb_enq = lsb_fire && !(grant_lsb && !lsb_head);
    assign alu_nxt = alu_head ? alu_mem[alu_rd] : alu_in;
    assign lsb_nxt = lsb_head ? lsb_mem[lsb_rd] : lsb_in;

    // NOTE: FIFO storage is not reset; pointers and counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (rst && !rollback && alu_enq) alu_mem[alu_wr] <= alu_in;
        if (rst && !rollback && lsb_enq) lsb_mem[lsb_wr] <= lsb_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_rd      <= '0;
            alu_wr      <= '0;
            alu_cnt     <= '0;
            lsb_rd      <= '0;
            lsb_wr      <= '0;
            lsb_cnt     <= '0;
            rr_lsb_last <= 1'b1;
            cdb_valid   <= 1'b0;
            cdb_src     <= 1'b0;
            cdb_val     <= '0;
            cdb_rob_pos <= '0;
            cdb_j       <= 1'b0;
            cdb_pc      <= '0;
        end else if (rdy) begin
            if (rollback) begin
                alu_rd    <= '0;
                alu_wr    <= '0;
                alu_cnt   <= '0;
                lsb_rd    <= '0;
                lsb_wr    <= '0;
                lsb_cnt   <= '0;
                cdb_valid <= 1'b0;
            end else begin
                if (alu_enq) alu_wr <= alu_wr + 1'b1;
                if (alu_deq) alu_rd <= alu_rd + 1'b1;
                if (lsb_enq) lsb_wr <= lsb_wr + 1'b1;
                if (lsb_deq) lsb_rd <= lsb_rd + 1'b1;
                alu_cnt   <= alu_cnt + CNT_W'(alu_enq) - CNT_W'(alu_deq);
                lsb_cnt   <= lsb_cnt + CNT_W'(lsb_enq) - CNT_W'(lsb_deq);
                cdb_valid <= grant_alu || grant_lsb;
                if (grant_alu) begin
                    rr_lsb_last <= 1'b0;
                    cdb_src     <= 1'b0;
                    cdb_val     <= alu_nxt.val;
                    cdb_rob_pos <= alu_nxt.rob_pos;
                    cdb_j       <= alu_nxt.j;
                    cdb_pc      <= alu_nxt.pc;
                end else if (grant_lsb) begin
                    rr_lsb_last <= 1'b1;
                    cdb_src     <= 1'b1;
                    cdb_val     <= lsb_nxt.val;
                    cdb_rob_pos <= lsb_nxt.rob_pos;
                    cdb_j       <= 1'b0;
                    cdb_pc      <= '0;
                end
            end
        end
    end
endmodule
